// File: rtl/rv32i_types_pkg.sv
// Shared RV32I encodings and the MEM-stage handshake state type.
package rv32i_types;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } store_funct3_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10
    } mem_state_t;

endpackage

// File: rtl/mem_align_unit.sv
// Combinational load extraction/extension and store replication/byte-mask generation.
module mem_align_unit #(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      off,
    input  logic [XLEN-1:0] load_word,
    input  logic [XLEN-1:0] rs2,
    output logic [XLEN-1:0] load_data,
    output logic [XLEN-1:0] store_data,
    output logic [3:0]      byte_mask
);
    import rv32i_types::*;

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = load_word[{off, 3'b000} +: 8];
        sel_half = off[1] ? load_word[31:16] : load_word[15:0];
        case (funct3)
            LB:      load_data = {{24{sel_byte[7]}}, sel_byte};
            LH:      load_data = {{16{sel_half[15]}}, sel_half};
            LW:      load_data = load_word;
            LBU:     load_data = {24'd0, sel_byte};
            LHU:     load_data = {16'd0, sel_half};
            default: load_data = '0;
        endcase
    end

    // Data is replicated across lanes so the cache only needs the byte mask.
    always_comb begin
        case (funct3)
            SB: begin
                store_data = {4{rs2[7:0]}};
                byte_mask  = 4'b0001 << off;
            end
            SH: begin
                store_data = {2{rs2[15:0]}};
                byte_mask  = 4'b0011 << off;
            end
            SW: begin
                store_data = rs2;
                byte_mask  = 4'hF;
            end
            default: begin
                store_data = rs2;
                byte_mask  = 4'h0;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: data-cache load/store handshake, alignment, and stall generation.
module mem_access_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic            mem_read_i,
    input  logic            mem_write_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] alu_out_i,
    input  logic [XLEN-1:0] rs2_out_i,
    input  logic            advance_i,
    input  logic [XLEN-1:0] dcache_rdata,
    input  logic            dcache_resp,
    output logic            dcache_read,
    output logic            dcache_write,
    output logic [XLEN-1:0] dcache_address,
    output logic [XLEN-1:0] dcache_wdata,
    output logic [3:0]      dcache_mem_byte_enable,
    output logic [XLEN-1:0] mem_rdata_o,
    output logic            misaligned_o,
    output logic            stall_o
);
    import rv32i_types::*;

    mem_state_t      state;
    logic            req_is_read;
    logic            req_is_write;
    logic [XLEN-1:0] rdata_cap;

    logic            need;
    logic            in_idle;
    logic            in_req;
    logic            issue_rd;
    logic            issue_wr;
    logic            resp_load;
    logic [XLEN-1:0] load_word;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] store_data;
    logic [3:0]      byte_mask;

    always_comb begin
        misaligned_o = valid_i & (mem_read_i | mem_write_i) &
                       (((funct3_i[1:0] == 2'b01) & alu_out_i[0]) |
                        ((funct3_i[1:0] == 2'b10) & (alu_out_i[1:0] != 2'b00)));
        need      = valid_i & (mem_read_i | mem_write_i) & ~misaligned_o;
        in_idle   = (state == IDLE);
        in_req    = (state == REQ);
        issue_rd  = in_idle & need & mem_read_i;
        issue_wr  = in_idle & need & mem_write_i;
        // The request kind is latched so a flush in REQ cannot retract an in-flight access.
        dcache_read  = rst & (issue_rd | (in_req & req_is_read));
        dcache_write = rst & (issue_wr | (in_req & req_is_write));
        stall_o      = ((in_idle & need) | in_req) & ~dcache_resp;
        resp_load    = dcache_resp & (issue_rd | (in_req & req_is_read));

        dcache_address         = {alu_out_i[XLEN-1:2], 2'b00};
        dcache_wdata           = store_data;
        dcache_mem_byte_enable = dcache_write ? byte_mask : 4'h0;

        load_word   = (state == DONE) ? rdata_cap : dcache_rdata;
        mem_rdata_o = mem_read_i ? load_data : '0;
    end

    mem_align_unit #(.XLEN(XLEN)) u_align (
        .funct3     (funct3_i),
        .off        (alu_out_i[1:0]),
        .load_word  (load_word),
        .rs2        (rs2_out_i),
        .load_data  (load_data),
        .store_data (store_data),
        .byte_mask  (byte_mask)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            req_is_read  <= 1'b0;
            req_is_write <= 1'b0;
            rdata_cap    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (need) begin
                        req_is_read  <= mem_read_i;
                        req_is_write <= mem_write_i;
                        if (!dcache_resp)
                            state <= REQ;
                        else if (!advance_i)
                            state <= DONE;
                    end
                end
                REQ: begin
                    if (dcache_resp)
                        state <= advance_i ? IDLE : DONE;
                end
                DONE: begin
                    if (advance_i)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // A response seen in DONE is not a live request and must not disturb the held word.
            if (resp_load)
                rdata_cap <= dcache_rdata;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage.
module tb_mem_access_stage;
    import rv32i_types::*;

    logic        clk;
    logic        rst;
    logic        valid_i;
    logic        mem_read_i;
    logic        mem_write_i;
    logic [2:0]  funct3_i;
    logic [31:0] alu_out_i;
    logic [31:0] rs2_out_i;
    logic        advance_i;
    logic [31:0] dcache_rdata;
    logic        dcache_resp;
    logic        dcache_read;
    logic        dcache_write;
    logic [31:0] dcache_address;
    logic [31:0] dcache_wdata;
    logic [3:0]  dcache_mem_byte_enable;
    logic [31:0] mem_rdata_o;
    logic        misaligned_o;
    logic        stall_o;

    int n_checks = 0;
    int n_fails  = 0;

    mem_access_stage #(.XLEN(32)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .valid_i                (valid_i),
        .mem_read_i             (mem_read_i),
        .mem_write_i            (mem_write_i),
        .funct3_i               (funct3_i),
        .alu_out_i              (alu_out_i),
        .rs2_out_i              (rs2_out_i),
        .advance_i              (advance_i),
        .dcache_rdata           (dcache_rdata),
        .dcache_resp            (dcache_resp),
        .dcache_read            (dcache_read),
        .dcache_write           (dcache_write),
        .dcache_address         (dcache_address),
        .dcache_wdata           (dcache_wdata),
        .dcache_mem_byte_enable (dcache_mem_byte_enable),
        .mem_rdata_o            (mem_rdata_o),
        .misaligned_o           (misaligned_o),
        .stall_o                (stall_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid_i     = 1'b0;
        mem_read_i  = 1'b0;
        mem_write_i = 1'b0;
        dcache_resp = 1'b0;
    endtask

    initial begin
        rst          = 1'b0;
        valid_i      = 1'b0;
        mem_read_i   = 1'b0;
        mem_write_i  = 1'b0;
        funct3_i     = 3'b000;
        alu_out_i    = 32'h0;
        rs2_out_i    = 32'h0;
        advance_i    = 1'b1;
        dcache_rdata = 32'h0;
        dcache_resp  = 1'b0;

        // Reset state
        next_cycle();
        next_cycle();
        chk("rst_read", {31'd0, dcache_read}, 32'd0);
        chk("rst_write", {31'd0, dcache_write}, 32'd0);
        chk("rst_state", 32'(dut.state), 32'(IDLE));
        chk("rst_cap", dut.rdata_cap, 32'h0);
        rst = 1'b1;
        next_cycle();

        // LW at 0x100, same-cycle response
        valid_i = 1'b1; mem_read_i = 1'b1; funct3_i = 3'b010;
        alu_out_i = 32'h100; dcache_rdata = 32'hDEADBEEF; dcache_resp = 1'b1; advance_i = 1'b1;
        #2;
        chk("lw_read", {31'd0, dcache_read}, 32'd1);
        chk("lw_stall", {31'd0, stall_o}, 32'd0);
        chk("lw_addr", dcache_address, 32'h100);
        chk("lw_rdata", mem_rdata_o, 32'hDEADBEEF);
        next_cycle();
        idle_inputs();
        #2;
        chk("lw_read_done", {31'd0, dcache_read}, 32'd0);
        chk("lw_state", 32'(dut.state), 32'(IDLE));

        // LB at 0x103, response on the fourth cycle
        next_cycle();
        valid_i = 1'b1; mem_read_i = 1'b1; funct3_i = 3'b000;
        alu_out_i = 32'h103; dcache_rdata = 32'h80FF0000; dcache_resp = 1'b0;
        #2;
        chk("lb_stall1", {31'd0, stall_o}, 32'd1);
        chk("lb_read1", {31'd0, dcache_read}, 32'd1);
        next_cycle();
        #2;
        chk("lb_state_req", 32'(dut.state), 32'(REQ));
        chk("lb_stall2", {31'd0, stall_o}, 32'd1);
        next_cycle();
        #2;
        chk("lb_stall3", {31'd0, stall_o}, 32'd1);
        chk("lb_read3", {31'd0, dcache_read}, 32'd1);
        next_cycle();
        dcache_resp = 1'b1;
        #2;
        chk("lb_stall4", {31'd0, stall_o}, 32'd0);
        chk("lb_rdata", mem_rdata_o, 32'hFFFFFF80);
        next_cycle();
        chk("lb_back_idle", 32'(dut.state), 32'(IDLE));

        // LBU on the same data, same-cycle response
        funct3_i = 3'b100;
        #2;
        chk("lbu_rdata", mem_rdata_o, 32'h00000080);
        chk("lbu_stall", {31'd0, stall_o}, 32'd0);
        next_cycle();
        idle_inputs();

        // LH at 0x102 and LHU at 0x002 on 0x80FF0000
        funct3_i = 3'b001; alu_out_i = 32'h102; valid_i = 1'b1; mem_read_i = 1'b1; dcache_resp = 1'b1;
        #2;
        chk("lh_rdata", mem_rdata_o, 32'hFFFF80FF);
        funct3_i = 3'b101; alu_out_i = 32'h000;
        #1;
        chk("lhu_rdata", mem_rdata_o, 32'h00000000);
        next_cycle();
        idle_inputs();

        // SH at 0x202, response on the third cycle
        next_cycle();
        valid_i = 1'b1; mem_write_i = 1'b1; funct3_i = 3'b001;
        alu_out_i = 32'h202; rs2_out_i = 32'h1234ABCD; dcache_resp = 1'b0;
        #2;
        chk("sh_write1", {31'd0, dcache_write}, 32'd1);
        chk("sh_read1", {31'd0, dcache_read}, 32'd0);
        chk("sh_addr", dcache_address, 32'h200);
        chk("sh_wdata", dcache_wdata, 32'hABCDABCD);
        chk("sh_mask", {28'd0, dcache_mem_byte_enable}, 32'hC);
        chk("sh_stall1", {31'd0, stall_o}, 32'd1);
        chk("sh_rdata_zero", mem_rdata_o, 32'h0);
        next_cycle();
        #2;
        chk("sh_write2", {31'd0, dcache_write}, 32'd1);
        chk("sh_mask2", {28'd0, dcache_mem_byte_enable}, 32'hC);
        next_cycle();
        dcache_resp = 1'b1;
        #2;
        chk("sh_stall3", {31'd0, stall_o}, 32'd0);
        next_cycle();
        idle_inputs();
        #2;
        chk("sh_write_off", {31'd0, dcache_write}, 32'd0);
        chk("sh_mask_off", {28'd0, dcache_mem_byte_enable}, 32'h0);

        // SB at 0x201 and SW at 0x204, same-cycle responses
        next_cycle();
        valid_i = 1'b1; mem_write_i = 1'b1; funct3_i = 3'b000;
        alu_out_i = 32'h201; rs2_out_i = 32'h000000A5; dcache_resp = 1'b1;
        #2;
        chk("sb_wdata", dcache_wdata, 32'hA5A5A5A5);
        chk("sb_mask", {28'd0, dcache_mem_byte_enable}, 32'h2);
        funct3_i = 3'b010; alu_out_i = 32'h204; rs2_out_i = 32'h01020304;
        #1;
        chk("sw_wdata", dcache_wdata, 32'h01020304);
        chk("sw_mask", {28'd0, dcache_mem_byte_enable}, 32'hF);
        next_cycle();
        idle_inputs();

        // LW held in DONE by advance_i=0
        next_cycle();
        valid_i = 1'b1; mem_read_i = 1'b1; funct3_i = 3'b010;
        alu_out_i = 32'h10C; dcache_rdata = 32'hCAFEF00D; dcache_resp = 1'b1; advance_i = 1'b0;
        #2;
        chk("hold_rdata0", mem_rdata_o, 32'hCAFEF00D);
        chk("hold_stall0", {31'd0, stall_o}, 32'd0);
        next_cycle();
        dcache_resp = 1'b0; dcache_rdata = 32'h0;
        #2;
        chk("hold_state", 32'(dut.state), 32'(DONE));
        chk("hold_read1", {31'd0, dcache_read}, 32'd0);
        chk("hold_stall1", {31'd0, stall_o}, 32'd0);
        chk("hold_rdata1", mem_rdata_o, 32'hCAFEF00D);
        next_cycle();
        dcache_resp = 1'b1; dcache_rdata = 32'h11111111;
        #2;
        chk("hold_rdata2", mem_rdata_o, 32'hCAFEF00D);
        chk("hold_read2", {31'd0, dcache_read}, 32'd0);
        next_cycle();
        dcache_resp = 1'b0; advance_i = 1'b1;
        #2;
        chk("hold_state3", 32'(dut.state), 32'(DONE));
        chk("hold_rdata3", mem_rdata_o, 32'hCAFEF00D);
        next_cycle();
        idle_inputs();
        #2;
        chk("hold_release", 32'(dut.state), 32'(IDLE));

        // Misaligned accesses
        next_cycle();
        valid_i = 1'b1; mem_read_i = 1'b1; funct3_i = 3'b010; alu_out_i = 32'h101;
        #2;
        chk("mis_lw_flag", {31'd0, misaligned_o}, 32'd1);
        chk("mis_lw_read", {31'd0, dcache_read}, 32'd0);
        chk("mis_lw_stall", {31'd0, stall_o}, 32'd0);
        mem_read_i = 1'b0; mem_write_i = 1'b1; funct3_i = 3'b001; alu_out_i = 32'h203;
        #1;
        chk("mis_sh_flag", {31'd0, misaligned_o}, 32'd1);
        chk("mis_sh_write", {31'd0, dcache_write}, 32'd0);
        chk("mis_sh_mask", {28'd0, dcache_mem_byte_enable}, 32'h0);
        valid_i = 1'b0;
        #1;
        chk("mis_novalid", {31'd0, misaligned_o}, 32'd0);
        next_cycle();
        chk("mis_state", 32'(dut.state), 32'(IDLE));
        idle_inputs();

        // Flush while in REQ: access completes anyway
        next_cycle();
        valid_i = 1'b1; mem_read_i = 1'b1; funct3_i = 3'b010; alu_out_i = 32'h120;
        dcache_rdata = 32'h55AA55AA;
        next_cycle();
        valid_i = 1'b0; mem_read_i = 1'b0;
        #2;
        chk("flush_read", {31'd0, dcache_read}, 32'd1);
        chk("flush_stall", {31'd0, stall_o}, 32'd1);
        next_cycle();
        dcache_resp = 1'b1;
        next_cycle();
        dcache_resp = 1'b0;
        #2;
        chk("flush_idle", 32'(dut.state), 32'(IDLE));
        chk("flush_cap", dut.rdata_cap, 32'h55AA55AA);

        // Asynchronous reset in the middle of REQ
        next_cycle();
        valid_i = 1'b1; mem_read_i = 1'b1; funct3_i = 3'b010; alu_out_i = 32'h110;
        next_cycle();
        #2;
        chk("arst_pre_req", 32'(dut.state), 32'(REQ));
        rst = 1'b0;
        #1;
        chk("arst_read", {31'd0, dcache_read}, 32'd0);
        chk("arst_state", 32'(dut.state), 32'(IDLE));
        chk("arst_cap", dut.rdata_cap, 32'h0);
        next_cycle();
        idle_inputs();
        rst = 1'b1;
        next_cycle();
        #2;
        chk("post_rst_read", {31'd0, dcache_read}, 32'd0);
        chk("post_rst_stall", {31'd0, stall_o}, 32'd0);
        chk("post_rst_state", 32'(dut.state), 32'(IDLE));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Pipeline MEM stage; sits between the EX/MEM stage latch and the MEM/WB stage latch.
- Consumes the EX/MEM latch outputs and runs the load/store handshake with the data cache.
- Aligns and extends load data, and generates store data and byte enables.
- Raises a stall to the hazard unit until the access completes; results feed the MEM/WB latch inputs.

Parameters:
XLEN, 32, datapath/address width; only 32 is supported.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset; asynchronous, active-low.
valid_i  in  1  EX/MEM holds a live instruction.
mem_read_i  in  1  instruction is a load.
mem_write_i  in  1  instruction is a store.
funct3_i  in  3  access size/sign (RV32I LB/LH/LW/LBU/LHU, SB/SH/SW encodings).
alu_out_i  in  XLEN  effective byte address.
rs2_out_i  in  XLEN  store source data.
advance_i  in  1  MEM/WB latch load this cycle, from the hazard unit, excluding this block's own stall.
dcache_rdata  in  XLEN  cache read word.
dcache_resp  in  1  cache completes the current request this cycle.
dcache_read  out  1  read request.
dcache_write  out  1  write request.
dcache_address  out  XLEN  word address: {alu_out_i[31:2],2'b00}.
dcache_wdata  out  XLEN  replicated store data.
dcache_mem_byte_enable  out  4  store byte mask.
mem_rdata_o  out  XLEN  aligned, extended load result.
misaligned_o  out  1  illegal alignment; access suppressed.
stall_o  out  1  hold all upstream latches.

Behaviour:
- FSM states: IDLE, REQ, DONE. Reset (rst low, async) forces IDLE, clears the capture register to 0, and forces dcache_read=dcache_write=0 while rst is low.
- need = valid_i & (mem_read_i | mem_write_i) & ~misaligned_o.
- Misalignment:
  - LH/LHU/SH with alu_out_i[0]=1 is misaligned.
  - LW/SW with alu_out_i[1:0]≠0 is misaligned.
  - misaligned_o is combinational and asserted only when valid_i is high.
  - A misaligned access issues no request and does not stall.
- Request issue: dcache_read/dcache_write are asserted combinationally in IDLE when need is high (read for loads, write for stores), and held in REQ. Address, data and mask must stay stable while they are asserted.
- stall_o = (IDLE&need | REQ) & ~dcache_resp. A same-cycle response gives zero stall cycles. Every extra cycle before dcache_resp adds one stall cycle.
- Transitions:
  - IDLE→REQ: need & ~dcache_resp.
  - IDLE→DONE: need & dcache_resp & ~advance_i.
  - REQ→DONE: dcache_resp & ~advance_i.
  - REQ→IDLE: dcache_resp & advance_i.
  - DONE→IDLE: advance_i.
  - All other cases hold state.
- Capture: on dcache_resp for a load, the raw dcache_rdata is registered.
- DONE:
  - No request is reissued and stall_o=0.
  - mem_rdata_o is formed from the captured word, so a downstream stall never repeats a cache access.
- Load alignment (off = alu_out_i[1:0]):
  - LB/LBU select byte off, sign- or zero-extended.
  - LH/LHU select half off[1], sign- or zero-extended.
  - LW passes the word.
  - mem_rdata_o is formed from dcache_rdata in IDLE/REQ and from the capture register in DONE; it is 0 for non-loads.
- Store data and mask:
  - SB: wdata = {4{rs2[7:0]}}, mask = 4'b0001<<off.
  - SH: wdata = {2{rs2[15:0]}}, mask = 4'b0011<<off.
  - SW: wdata = rs2, mask = 4'hF.
  - Mask is 0 when no store is being issued.
- A dcache_resp arriving in DONE is ignored.
- valid_i dropping while in REQ (flush) does not abort the access. The block completes it and then returns to IDLE per the advance_i rules.

Decomposition:
- Shared rv32i_types package holds the load_funct3/store_funct3 enumerations and a mem_state_t enum (IDLE, REQ, DONE).
- Natural sub-module: mem_align_unit, combinational; covers load extraction/extension and store replication/mask.

Test Plan:
- LW at 0x100, dcache_resp in the same cycle, rdata 0xDEADBEEF → dcache_read=1 for 1 cycle, stall_o=0, mem_rdata_o=0xDEADBEEF.
- LB at 0x103, rdata 0x80FF_0000, resp after 3 cycles → stall_o high for 3 cycles; mem_rdata_o=0xFFFFFF80. LBU on the same data → 0x00000080.
- SH at 0x202, rs2=0x1234ABCD → dcache_address=0x200, wdata=0xABCDABCD, mask=4'b1100, dcache_write held until resp.
- LW, resp with advance_i=0 for 2 cycles, then rdata changes to 0 → state DONE, no new dcache_read, mem_rdata_o keeps its captured value until advance_i=1.
- LW at 0x101 → misaligned_o=1, dcache_read=0, stall_o=0.
- rst driven low mid-REQ, asynchronously between clock edges → dcache_read drops immediately, state IDLE, capture register=0. After release with valid_i=0 → no request.
